// File: rtl/stream_pkg.sv
// Shared types, default widths and the sequence helper for the stream receiver.
package stream_pkg;

  localparam int DEF_DW = 32;
  localparam int DEF_CW = 16;
  localparam int MAX_DW = 64;

  typedef enum logic [0:0] {
    READY = 1'b0,
    GAP   = 1'b1
  } state_t;

  // Value expected after a beat carrying data; callers truncate to their width.
  function automatic logic [MAX_DW-1:0] next_expected(input logic [MAX_DW-1:0] data);
    return data + 64'd1;
  endfunction

endpackage

// File: rtl/stream_rx_checker_sat_counter.sv
// Saturating up-counter: increments on inc and holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count register, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/stream_rx_checker.sv
// Stream receiver: throttles acceptance with a ready-low gap, checks that data
// increments by one per beat and that the sender keeps valid/data stable while stalled.
module stream_rx_checker
  import stream_pkg::*;
#(
  parameter int              DW    = DEF_DW,
  parameter int              DELAY = 0,
  parameter logic [DW-1:0]   START = '0,
  parameter int              CW    = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  output logic          up_ready,
  output logic [CW-1:0] beat_cnt,
  output logic [CW-1:0] err_cnt,
  output logic          data_err,
  output logic          proto_err,
  output logic [DW-1:0] last_bad
);

  localparam int GW = (DELAY > 2) ? $clog2(DELAY) : 1;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [GW-1:0]   gap_r;
  logic [GW-1:0]   gap_nxt_s;
  logic [DW-1:0]   expected_r;
  logic            prev_valid_r;
  logic            prev_ready_r;
  logic [DW-1:0]   prev_data_r;
  logic            xfer_s;
  logic            match_s;
  logic            violation_s;

  assign xfer_s      = up_valid & up_ready;
  assign match_s     = (up_data == expected_r);
  assign violation_s = prev_valid_r & ~prev_ready_r & (~up_valid | (up_data != prev_data_r));

  // Next-state logic for the throttle: the gap counter runs DELAY-1 down to 0.
  always_comb begin
    state_nxt_s = state_r;
    gap_nxt_s   = gap_r;
    case (state_r)
      READY: begin
        if (xfer_s && (DELAY > 0)) begin
          state_nxt_s = GAP;
          gap_nxt_s   = GW'(DELAY - 1);
        end else begin
          state_nxt_s = READY;
        end
      end
      GAP: begin
        if (gap_r == '0) begin
          state_nxt_s = READY;
        end else begin
          gap_nxt_s = gap_r - GW'(1);
        end
      end
      default: begin
        state_nxt_s = READY;
        gap_nxt_s   = '0;
      end
    endcase
  end

  // Throttle state, registered ready, sequence tracking and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= READY;
      gap_r        <= '0;
      up_ready     <= 1'b0;
      expected_r   <= START;
      data_err     <= 1'b0;
      proto_err    <= 1'b0;
      last_bad     <= '0;
      prev_valid_r <= 1'b0;
      prev_ready_r <= 1'b0;
      prev_data_r  <= '0;
    end else begin
      state_r      <= state_nxt_s;
      gap_r        <= gap_nxt_s;
      up_ready     <= (state_nxt_s == READY);
      prev_valid_r <= up_valid;
      prev_ready_r <= up_ready;
      prev_data_r  <= up_data;
      if (xfer_s) begin
        // On a match up_data equals expected; on a mismatch this resynchronises.
        expected_r <= DW'(next_expected(MAX_DW'(up_data)));
        if (!match_s) begin
          data_err <= 1'b1;
          last_bad <= up_data;
        end
      end
      if (violation_s) begin
        proto_err <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CW)) u_beat_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (xfer_s),
    .count (beat_cnt)
  );

  sat_counter #(.W(CW)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (xfer_s & ~match_s),
    .count (err_cnt)
  );

endmodule

// File: tb/tb_stream_rx_checker.sv
// Bench for stream_rx_checker: scoreboard on a DELAY=0 instance plus directed
// checks on throttled, narrow/saturating and protocol-violation instances.
module tb_stream_rx_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: DELAY=0, DW=32, START=0, CW=16
  logic        rst_a = 1'b0, a_valid = 1'b0, a_ready, a_derr, a_perr;
  logic [31:0] a_data = '0, a_last;
  logic [15:0] a_beat, a_err;
  // Instance B: DELAY=3
  logic        rst_b = 1'b0, b_valid = 1'b0, b_ready, b_derr, b_perr;
  logic [31:0] b_data = '0, b_last;
  logic [15:0] b_beat, b_err;
  // Instance C: DW=8, START=FE, CW=2
  logic        rst_c = 1'b0, c_valid = 1'b0, c_ready, c_derr, c_perr;
  logic [7:0]  c_data = '0, c_last;
  logic [1:0]  c_beat, c_err;
  // Instance D: DELAY=2
  logic        rst_d = 1'b0, d_valid = 1'b0, d_ready, d_derr, d_perr;
  logic [31:0] d_data = '0, d_last;
  logic [15:0] d_beat, d_err;

  stream_rx_checker #(.DW(32), .DELAY(0), .START(32'd0), .CW(16)) u_a (
    .clk(clk), .rst(rst_a), .up_valid(a_valid), .up_data(a_data), .up_ready(a_ready),
    .beat_cnt(a_beat), .err_cnt(a_err), .data_err(a_derr), .proto_err(a_perr), .last_bad(a_last));
  stream_rx_checker #(.DW(32), .DELAY(3), .START(32'd0), .CW(16)) u_b (
    .clk(clk), .rst(rst_b), .up_valid(b_valid), .up_data(b_data), .up_ready(b_ready),
    .beat_cnt(b_beat), .err_cnt(b_err), .data_err(b_derr), .proto_err(b_perr), .last_bad(b_last));
  stream_rx_checker #(.DW(8), .DELAY(0), .START(8'hFE), .CW(2)) u_c (
    .clk(clk), .rst(rst_c), .up_valid(c_valid), .up_data(c_data), .up_ready(c_ready),
    .beat_cnt(c_beat), .err_cnt(c_err), .data_err(c_derr), .proto_err(c_perr), .last_bad(c_last));
  stream_rx_checker #(.DW(32), .DELAY(2), .START(32'd0), .CW(16)) u_d (
    .clk(clk), .rst(rst_d), .up_valid(d_valid), .up_data(d_data), .up_ready(d_ready),
    .beat_cnt(d_beat), .err_cnt(d_err), .data_err(d_derr), .proto_err(d_perr), .last_bad(d_last));

  typedef struct {
    logic [15:0] beat;
    logic [15:0] err;
    logic        derr;
    logic [31:0] last;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  logic a_pend = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: one negedge after each accepted beat on A, compare status.
  always @(negedge clk) begin
    if (a_pend) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        got = sb.pop_front();
        chk("a_beat_cnt", 64'(a_beat), 64'(got.beat));
        chk("a_err_cnt",  64'(a_err),  64'(got.err));
        chk("a_data_err", 64'(a_derr), 64'(got.derr));
        chk("a_last_bad", 64'(a_last), 64'(got.last));
      end
    end
    a_pend = a_valid && a_ready && rst_a;
  end

  task automatic send_a(input logic [31:0] d, input logic [15:0] eb, input logic [15:0] ee,
                        input logic ed, input logic [31:0] el);
    bit done;
    sb.push_back('{beat: eb, err: ee, derr: ed, last: el});
    a_valid = 1'b1;
    a_data  = d;
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      done = a_ready;
    end
    if (!done) chk("a_send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #2;
  endtask

  int t0;
  initial begin
    // Reset: all instances held for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_ready", 64'(a_ready), 64'd0);
    end
    chk("rst_beat", 64'(a_beat), 64'd0);
    chk("rst_err",  64'(a_err),  64'd0);
    chk("rst_flags", 64'({a_derr, a_perr}), 64'd0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    @(posedge clk); #1;
    chk("release_ready", 64'(a_ready), 64'd1);

    // Clean stream 0..9 back to back.
    #1;
    t0 = cyc;
    for (int i = 0; i < 10; i++) send_a(32'(i), 16'(i + 1), 16'd0, 1'b0, 32'd0);
    a_valid = 1'b0;
    chk("clean_cycles", 64'(cyc - t0), 64'd10);
    @(negedge clk);
    chk("clean_beat", 64'(a_beat), 64'd10);

    // Mismatch/resync on a freshly reset A.
    @(posedge clk); #2;
    rst_a = 1'b0;
    #1;
    chk("a_rst_beat", 64'(a_beat), 64'd0);
    @(negedge clk); rst_a = 1'b1;
    @(posedge clk); #2;
    send_a(32'd0, 16'd1, 16'd0, 1'b0, 32'd0);
    send_a(32'd1, 16'd2, 16'd0, 1'b0, 32'd0);
    send_a(32'd7, 16'd3, 16'd1, 1'b1, 32'd7);
    send_a(32'd8, 16'd4, 16'd1, 1'b1, 32'd7);
    send_a(32'd9, 16'd5, 16'd1, 1'b1, 32'd7);
    a_valid = 1'b0;
    @(negedge clk);
    chk("a_proto_clean", 64'(a_perr), 64'd0);

    // Throttling: DELAY=3, sender always valid.
    @(posedge clk); #2;
    b_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("b_ready_pattern", 64'(b_ready), 64'((i % 4) == 0));
      if (b_ready) begin
        @(posedge clk); #2;
        b_data = b_data + 32'd1;
      end
    end
    b_valid = 1'b0;
    chk("b_beat", 64'(b_beat), 64'd5);
    chk("b_flags", 64'({b_derr, b_perr, b_err}), 64'd0);

    // Wrap FE,FF,00 and CW=2 saturation.
    @(posedge clk); #2;
    c_valid = 1'b1;
    c_data  = 8'hFE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("c_ready", 64'(c_ready), 64'd1);
      @(posedge clk); #2;
      if (i == 2) begin
        chk("c_wrap_beat", 64'(c_beat), 64'd3);
        chk("c_wrap_err", 64'({c_derr, c_err}), 64'd0);
      end
      c_data = c_data + 8'd1;
    end
    c_valid = 1'b0;
    chk("c_sat_beat", 64'(c_beat), 64'd3);
    chk("c_sat_err", 64'({c_derr, c_err}), 64'd0);

    // Protocol: data changed while stalled in GAP.
    @(posedge clk); #2;
    d_valid = 1'b1; d_data = 32'd0;
    @(posedge clk); #2;
    d_data = 32'd5;
    @(negedge clk);
    chk("d_gap_ready", 64'(d_ready), 64'd0);
    @(posedge clk); #2;
    d_data = 32'd6;
    @(posedge clk); #2;
    d_valid = 1'b0;
    @(negedge clk);
    chk("d_chg_proto", 64'(d_perr), 64'd1);
    chk("d_chg_beat", 64'(d_beat), 64'd1);
    chk("d_chg_err", 64'({d_derr, d_err}), 64'd0);

    // Separate run: valid withdrawn during GAP.
    @(posedge clk); #2;
    rst_d = 1'b0;
    #1;
    chk("d_rst_proto", 64'(d_perr), 64'd0);
    @(negedge clk); rst_d = 1'b1;
    @(posedge clk); #2;
    d_valid = 1'b1; d_data = 32'd0;
    @(posedge clk); #2;
    d_data = 32'd5;
    @(posedge clk); #2;
    d_valid = 1'b0;
    @(posedge clk); #2;
    chk("d_drop_proto", 64'(d_perr), 64'd1);
    chk("d_drop_beat", 64'(d_beat), 64'd1);
    chk("d_drop_err", 64'(d_err), 64'd0);

    // Reset mid-stream with a beat presented.
    d_valid = 1'b1; d_data = 32'd1;
    #1;
    rst_d = 1'b0;
    #1;
    chk("d_mid_proto", 64'(d_perr), 64'd0);
    chk("d_mid_beat", 64'(d_beat), 64'd0);
    chk("d_mid_ready", 64'(d_ready), 64'd0);
    @(posedge clk); #2;
    chk("d_mid_inflight", 64'(d_beat), 64'd0);
    d_valid = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stream_rx_checker.md
Name: stream_rx_checker

Overview:
- Receiving end of the valid/ready data stream driven by the stream generator.
- Throttles acceptance with a programmable ready-low gap after each accepted beat.
- Checks that accepted data forms an incrementing sequence, and checks the sender's handshake discipline.
- Exposes saturating beat/error counters and sticky error flags to the testbench.

Parameters:
- DW, 32, data width in bits.
- DELAY, 0, number of cycles up_ready is held low after each accepted beat; 0 means no throttling.
- START, 0, expected value of the first beat after reset (DW bits).
- CW, 16, width of the beat and error counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- up_valid  in  1  sender has a beat.
- up_data  in  DW  beat payload.
- up_ready  out  1  receiver accepts; a beat transfers when up_valid & up_ready at a rising edge.
- beat_cnt  out  CW  accepted beats, saturating.
- err_cnt  out  CW  data mismatches, saturating.
- data_err  out  1  sticky; set on the first mismatch.
- proto_err  out  1  sticky; set on the first handshake violation.
- last_bad  out  DW  up_data of the most recent mismatching beat.

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0. Internal state: state=READY, gap counter=0, expected=START.
- Release: up_ready is registered. It rises on the first clk edge after rst deasserts.
- State READY:
  - up_ready=1.
  - On a transfer: if DELAY>0, go to GAP with gap counter=DELAY-1. Otherwise stay in READY.
- State GAP:
  - up_ready=0. The gap counter decrements each cycle.
  - When the counter is 0, return to READY; up_ready is 1 on the next cycle.
  - Total ready-low time is exactly DELAY cycles per beat.
- Data check on every transfer:
  - If up_data == expected: expected <= expected+1.
  - Otherwise: err_cnt increments, data_err <= 1, last_bad <= up_data, and expected <= up_data+1 (resynchronise, so a single corrupt beat costs one error).
  - expected wraps modulo 2^DW (all-ones is followed by 0 with no error).
- beat_cnt increments on every transfer.
- Both counters saturate at 2^CW-1 and hold there.
- Protocol check uses registered previous-cycle values of up_valid, up_data and up_ready. A violation exists when the previous cycle had up_valid=1 and up_ready=0, and in the current cycle either:
  - up_valid=0 (valid withdrawn before acceptance), or
  - up_data differs from its previous value (data changed while stalled).
- On a violation: proto_err <= 1 (sticky). No counter changes.
- proto_err and data_err clear only on reset.
- up_ready does not depend combinationally on up_valid.
- Simultaneous mismatch and protocol violation: both flags set in the same cycle.
- Reset asserted mid-stream: everything returns to reset values immediately. A beat in flight is not counted.

Decomposition:
- Package stream_pkg holds:
  - default DW/CW constants;
  - typedef for the two-value state enum (READY, GAP);
  - function next_expected(data) = data+1.
- One sub-module, sat_counter:
  - parameter W;
  - ports clk, rst, inc, count;
  - saturating increment.
  - Instantiated twice, for beat_cnt and err_cnt.

Test Plan:
- Reset/idle: hold rst=0 for 5 cycles, then release with up_valid=0 → up_ready=0 during reset and 1 from the first edge after release; all counters 0.
- Clean stream: DELAY=0, START=0, send 0..9 back-to-back → 10 transfers in 10 cycles, beat_cnt=10, err_cnt=0, data_err=0.
- Throttling: DELAY=3, sender always valid → each up_ready-high cycle followed by exactly 3 low cycles; 5 beats take 20 cycles.
- Mismatch/resync: send 0,1,7,8,9 → err_cnt=1, last_bad=7, data_err=1; beats 8 and 9 accepted without further error.
- Wrap and saturation:
  - DW=8, START=8'hFE, send FE,FF,00 → no error.
  - CW=2, 5 clean beats → beat_cnt holds at 3.
- Protocol violations:
  - DELAY=2: present data 5 during GAP, change it to 6 before ready → proto_err=1, err_cnt unchanged.
  - Separate run: drop valid during GAP → proto_err=1.
  - Then assert rst mid-stream → proto_err=0, beat_cnt=0.
